// File: rtl/bc_v2_pkg.sv
// Shared constants for the second-generation basic-computer datapath:
// bus source codes, register slot indices, ALU opcodes, memory FSM states.
package bc_v2_pkg;

  localparam logic [3:0] SEL_AR   = 4'd0;
  localparam logic [3:0] SEL_PC   = 4'd1;
  localparam logic [3:0] SEL_DR   = 4'd2;
  localparam logic [3:0] SEL_AC   = 4'd3;
  localparam logic [3:0] SEL_IR   = 4'd4;
  localparam logic [3:0] SEL_TR   = 4'd5;
  localparam logic [3:0] SEL_MDR  = 4'd6;
  localparam logic [3:0] SEL_WRD  = 4'd7;
  localparam logic [3:0] SEL_GPR0 = 4'd8;

  // Bit positions inside the LD/INR/CLR control vectors
  localparam int R_AR = 0;
  localparam int R_PC = 1;
  localparam int R_DR = 2;
  localparam int R_AC = 3;
  localparam int R_IR = 4;
  localparam int R_TR = 5;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_XFER = 3'b010;
  localparam logic [2:0] OP_CMA  = 3'b011;
  localparam logic [2:0] OP_CIR  = 3'b100;
  localparam logic [2:0] OP_CIL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/bc_alu_v2.sv
// Combinational ALU on AC/DR/E with carry, zero, negative and signed-overflow flags.
module bc_alu_v2
  import bc_v2_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] dr_i,
  input  logic              e_i,
  output logic [DATA_W-1:0] res_o,
  output logic              co_o,
  output logic              z_o,
  output logic              n_o,
  output logic              ovf_o
);

  logic [DATA_W:0] sum_add;
  logic [DATA_W:0] sum_sub;

  assign sum_add = {1'b0, ac_i} + {1'b0, dr_i};
  // Subtraction as AC + ~DR + 1 so the carry out means "no borrow"
  assign sum_sub = {1'b0, ac_i} + {1'b0, ~dr_i} + (DATA_W+1)'(1);

  // Operation select; carry and overflow stay 0 unless the op defines them
  always_comb begin
    res_o = '0;
    co_o  = 1'b0;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = sum_add[DATA_W-1:0];
        co_o  = sum_add[DATA_W];
        ovf_o = (ac_i[DATA_W-1] == dr_i[DATA_W-1]) &&
                (sum_add[DATA_W-1] != ac_i[DATA_W-1]);
      end
      OP_AND:  res_o = ac_i & dr_i;
      OP_XFER: res_o = dr_i;
      OP_CMA:  res_o = ~ac_i;
      OP_CIR: begin
        res_o = {e_i, ac_i[DATA_W-1:1]};
        co_o  = ac_i[0];
      end
      OP_CIL: begin
        res_o = {ac_i[DATA_W-2:0], e_i};
        co_o  = ac_i[DATA_W-1];
      end
      OP_SUB: begin
        res_o = sum_sub[DATA_W-1:0];
        co_o  = sum_sub[DATA_W];
        ovf_o = (ac_i[DATA_W-1] != dr_i[DATA_W-1]) &&
                (sum_sub[DATA_W-1] != ac_i[DATA_W-1]);
      end
      default: res_o = ac_i;
    endcase
  end

  assign z_o = ~|res_o;
  assign n_o = res_o[DATA_W-1];

endmodule

// File: rtl/bc_datapath_v2.sv
// Basic-computer datapath: shared bus, AR/PC/DR/AC/IR/TR, GPR file, ALU with E,
// and a req/ready memory port whose FSM freezes all register updates while busy.
//
// state      | meaning
// ST_IDLE    | no transaction; MEM_RD/MEM_WR may start one
// ST_RD_WAIT | read request out, waiting for mem_ready to capture MDR
// ST_WR_WAIT | write request out, waiting for mem_ready
module bc_datapath_v2
  import bc_v2_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int NUM_GPR = 4
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic [3:0]         BUS_SEL,
  input  logic [5:0]         LD,
  input  logic [5:0]         INR,
  input  logic [5:0]         CLR,
  input  logic [NUM_GPR-1:0] GPR_LD,
  input  logic [2:0]         OPSEL_ALU,
  input  logic               LD_E,
  input  logic               CMP_E,
  input  logic               CLR_E,
  input  logic               MEM_RD,
  input  logic               MEM_WR,
  input  logic [DATA_W-1:0]  WRD,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               BUSY,
  output logic               ERR,
  output logic [ADDR_W-1:0]  PC_OUT,
  output logic [ADDR_W-1:0]  AR_OUT,
  output logic [DATA_W-1:0]  IR_OUT,
  output logic [DATA_W-1:0]  AC_OUT,
  output logic [DATA_W-1:0]  DR_OUT,
  output logic               CO,
  output logic               Z,
  output logic               N,
  output logic               OVF,
  output logic               E_OUT
);

  logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic              e_q, e_d, err_q, err_d, req_q, req_d, we_q, we_d, busy_q;
  mem_state_e        state_q, state_d;

  logic [DATA_W-1:0] bus, alu_res;
  logic [5:0]        ld_g, inr_g, clr_g;
  logic              unused_ir_ctl;

  // CLR > LD > INR; increment wraps at the register's own width after truncation
  function automatic logic [DATA_W-1:0] reg_next(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] ld_val,
                                                 input logic clr, input logic ld,
                                                 input logic inr);
    if (clr) return '0;
    if (ld)  return ld_val;
    if (inr) return cur + DATA_W'(1);
    return cur;
  endfunction

  assign ld_g  = busy_q ? 6'b0 : LD;
  assign inr_g = busy_q ? 6'b0 : INR;
  assign clr_g = busy_q ? 6'b0 : CLR;
  // IR has no increment or clear path
  assign unused_ir_ctl = inr_g[R_IR] ^ clr_g[R_IR];

  // Shared bus mux; undefined codes and absent GPRs read as 0
  always_comb begin
    bus = '0;
    case (BUS_SEL)
      SEL_AR:  bus = DATA_W'(ar_q);
      SEL_PC:  bus = DATA_W'(pc_q);
      SEL_DR:  bus = dr_q;
      SEL_AC:  bus = ac_q;
      SEL_IR:  bus = ir_q;
      SEL_TR:  bus = tr_q;
      SEL_MDR: bus = mdr_q;
      SEL_WRD: bus = WRD;
      default: bus = '0;
    endcase
    for (int i = 0; i < NUM_GPR; i++) begin
      if (BUS_SEL == SEL_GPR0 + 4'(i)) bus = gpr_q[i];
    end
  end

  bc_alu_v2 #(.DATA_W(DATA_W)) u_alu (
    .op_i  (OPSEL_ALU),
    .ac_i  (ac_q),
    .dr_i  (dr_q),
    .e_i   (e_q),
    .res_o (alu_res),
    .co_o  (CO),
    .z_o   (Z),
    .n_o   (N),
    .ovf_o (OVF)
  );

  // Register file next-state; AC takes the ALU result instead of the bus
  always_comb begin
    ar_d = ADDR_W'(reg_next(DATA_W'(ar_q), bus, clr_g[R_AR], ld_g[R_AR], inr_g[R_AR]));
    pc_d = ADDR_W'(reg_next(DATA_W'(pc_q), bus, clr_g[R_PC], ld_g[R_PC], inr_g[R_PC]));
    dr_d = reg_next(dr_q, bus, clr_g[R_DR], ld_g[R_DR], inr_g[R_DR]);
    ac_d = reg_next(ac_q, alu_res, clr_g[R_AC], ld_g[R_AC], inr_g[R_AC]);
    ir_d = reg_next(ir_q, bus, 1'b0, ld_g[R_IR], 1'b0);
    tr_d = reg_next(tr_q, bus, clr_g[R_TR], ld_g[R_TR], inr_g[R_TR]);
    for (int i = 0; i < NUM_GPR; i++) begin
      gpr_d[i] = (GPR_LD[i] && !busy_q) ? bus : gpr_q[i];
    end
  end

  // E flip-flop: CLR_E > LD_E (take carry) > CMP_E
  always_comb begin
    e_d = e_q;
    if (!busy_q) begin
      if (CLR_E)      e_d = 1'b0;
      else if (LD_E)  e_d = CO;
      else if (CMP_E) e_d = ~e_q;
    end
  end

  // Memory FSM next-state; request fields are captured once at start and held
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (MEM_RD && MEM_WR) begin
          err_d = 1'b1;
        end else if (MEM_RD) begin
          addr_d  = ar_q;
          we_d    = 1'b0;
          req_d   = 1'b1;
          state_d = ST_RD_WAIT;
        end else if (MEM_WR) begin
          addr_d  = ar_q;
          wdata_d = bus;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
      e_q  <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
    end else begin
      ar_q <= ar_d;
      pc_q <= pc_d;
      dr_q <= dr_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      tr_q <= tr_d;
      e_q  <= e_d;
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  // Memory FSM state, port registers, MDR and sticky error
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign PC_OUT    = pc_q;
  assign AR_OUT    = ar_q;
  assign IR_OUT    = ir_q;
  assign AC_OUT    = ac_q;
  assign DR_OUT    = dr_q;
  assign E_OUT     = e_q;

endmodule

// File: tb/tb_bc_datapath_v2.sv
// Self-checking bench: directed scenarios plus a randomized phase, with an
// arithmetic reference model compared against every output on each falling edge.
module tb_bc_datapath_v2;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NG = 4;
  localparam longint MASK  = (longint'(1) << DW) - 1;
  localparam longint AMASK = (longint'(1) << AW) - 1;

  logic          clk = 1'b0;
  logic          RST_N = 1'b0;
  logic [3:0]    BUS_SEL = '0;
  logic [5:0]    LD = '0, INR = '0, CLR = '0;
  logic [NG-1:0] GPR_LD = '0;
  logic [2:0]    OPSEL_ALU = '0;
  logic          LD_E = 1'b0, CMP_E = 1'b0, CLR_E = 1'b0;
  logic          MEM_RD = 1'b0, MEM_WR = 1'b0;
  logic [DW-1:0] WRD = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_req, mem_we, BUSY, ERR, CO, Z, N, OVF, E_OUT;
  logic [AW-1:0] mem_addr, PC_OUT, AR_OUT;
  logic [DW-1:0] mem_wdata, IR_OUT, AC_OUT, DR_OUT;

  bc_datapath_v2 #(.DATA_W(DW), .ADDR_W(AW), .NUM_GPR(NG)) dut (
    .clk(clk), .RST_N(RST_N), .BUS_SEL(BUS_SEL), .LD(LD), .INR(INR), .CLR(CLR),
    .GPR_LD(GPR_LD), .OPSEL_ALU(OPSEL_ALU), .LD_E(LD_E), .CMP_E(CMP_E), .CLR_E(CLR_E),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .WRD(WRD), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .BUSY(BUSY), .ERR(ERR), .PC_OUT(PC_OUT), .AR_OUT(AR_OUT),
    .IR_OUT(IR_OUT), .AC_OUT(AC_OUT), .DR_OUT(DR_OUT), .CO(CO), .Z(Z), .N(N),
    .OVF(OVF), .E_OUT(E_OUT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: registers indexed AR,PC,DR,AC,IR,TR; mode 0 idle, 1 read, 2 write
  longint m_reg [6];
  longint m_gpr [NG];
  longint m_mdr, m_addr, m_wdata;
  int     m_mode;
  bit     m_e, m_err, m_req, m_we;

  function automatic longint rmask(input int i);
    return (i < 2) ? AMASK : MASK;
  endfunction

  function automatic longint sgn(input longint v);
    return (((v >> (DW-1)) & 1) != 0) ? v - (MASK + 1) : v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = 0;
    for (int i = 0; i < NG; i++) m_gpr[i] = 0;
    m_mdr = 0; m_addr = 0; m_wdata = 0; m_mode = 0;
    m_e = 0; m_err = 0; m_req = 0; m_we = 0;
  endtask

  function automatic longint m_bus();
    int s;
    s = int'(BUS_SEL);
    if (s < 6) return m_reg[s];
    if (s == 6) return m_mdr;
    if (s == 7) return longint'(WRD);
    if (s - 8 < NG) return m_gpr[s-8];
    return 0;
  endfunction

  task automatic m_alu(output longint res, output bit co, output bit ovf,
                       output bit z, output bit n);
    longint a, d, s, sv;
    a = m_reg[3]; d = m_reg[2];
    co = 0; ovf = 0; res = 0;
    case (int'(OPSEL_ALU))
      0: begin
        s = a + d; res = s & MASK; co = ((s >> DW) & 1) != 0;
        sv = sgn(a) + sgn(d); ovf = (sv > (MASK >> 1)) || (sv < -((MASK >> 1) + 1));
      end
      1: res = a & d;
      2: res = d;
      3: res = (~a) & MASK;
      4: begin res = (longint'(m_e) << (DW-1)) | (a >> 1); co = (a & 1) != 0; end
      5: begin res = ((a << 1) & MASK) | longint'(m_e); co = ((a >> (DW-1)) & 1) != 0; end
      6: begin
        s = a + ((~d) & MASK) + 1; res = s & MASK; co = ((s >> DW) & 1) != 0;
        sv = sgn(a) - sgn(d); ovf = (sv > (MASK >> 1)) || (sv < -((MASK >> 1) + 1));
      end
      default: res = a;
    endcase
    z = (res == 0);
    n = ((res >> (DW-1)) & 1) != 0;
  endtask

  task automatic m_step();
    longint bus, res, v;
    longint nr [6];
    bit co, ovf, z, n;
    bus = m_bus();
    m_alu(res, co, ovf, z, n);
    if (m_mode == 0) begin
      for (int i = 0; i < 6; i++) begin
        v = (i == 3) ? res : (bus & rmask(i));
        nr[i] = m_reg[i];
        if (i == 4) begin
          if (LD[i]) nr[i] = v;
        end else if (CLR[i]) nr[i] = 0;
        else if (LD[i])      nr[i] = v;
        else if (INR[i])     nr[i] = (m_reg[i] + 1) & rmask(i);
      end
      for (int g = 0; g < NG; g++) if (GPR_LD[g]) m_gpr[g] = bus;
      if (CLR_E)      m_e = 0;
      else if (LD_E)  m_e = co;
      else if (CMP_E) m_e = !m_e;
      if (MEM_RD && MEM_WR) m_err = 1;
      else if (MEM_RD) begin
        m_mode = 1; m_addr = m_reg[0]; m_we = 0; m_req = 1;
      end else if (MEM_WR) begin
        m_mode = 2; m_addr = m_reg[0]; m_wdata = bus; m_we = 1; m_req = 1;
      end
      for (int i = 0; i < 6; i++) m_reg[i] = nr[i];
    end else if (mem_ready) begin
      if (m_mode == 1) m_mdr = longint'(mem_rdata);
      m_mode = 0; m_req = 0;
    end
  endtask

  task automatic m_compare();
    longint res;
    bit co, ovf, z, n;
    m_alu(res, co, ovf, z, n);
    chk("AR_OUT", longint'(AR_OUT), m_reg[0]);
    chk("PC_OUT", longint'(PC_OUT), m_reg[1]);
    chk("DR_OUT", longint'(DR_OUT), m_reg[2]);
    chk("AC_OUT", longint'(AC_OUT), m_reg[3]);
    chk("IR_OUT", longint'(IR_OUT), m_reg[4]);
    chk("E_OUT", longint'(E_OUT), longint'(m_e));
    chk("BUSY", longint'(BUSY), longint'(m_mode != 0));
    chk("ERR", longint'(ERR), longint'(m_err));
    chk("mem_req", longint'(mem_req), longint'(m_req));
    chk("mem_we", longint'(mem_we), longint'(m_we));
    chk("mem_addr", longint'(mem_addr), m_addr);
    chk("mem_wdata", longint'(mem_wdata), m_wdata);
    chk("CO", longint'(CO), longint'(co));
    chk("OVF", longint'(OVF), longint'(ovf));
    chk("Z", longint'(Z), longint'(z));
    chk("N", longint'(N), longint'(n));
  endtask

  // Single compare process: inputs are stable at the falling edge
  always @(negedge clk) begin
    if (!RST_N) m_reset();
    m_compare();
    if (RST_N) m_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    LD = '0; INR = '0; CLR = '0; GPR_LD = '0;
    LD_E = 0; CMP_E = 0; CLR_E = 0; MEM_RD = 0; MEM_WR = 0; mem_ready = 0;
  endtask

  task automatic load_dr_ac(input logic [DW-1:0] v);
    idle(); WRD = v; BUS_SEL = 4'd7; LD = 6'b000100; cyc();
    LD = 6'b001000; OPSEL_ALU = 3'd2; cyc();
    idle();
  endtask

  initial begin
    idle();
    RST_N = 0; cyc(); cyc();
    RST_N = 1;
    chk("rst_ar", longint'(AR_OUT), 0);
    chk("rst_busy", longint'(BUSY), 0);

    // Reset mid-read and bus load of AR
    WRD = 16'h1234; BUS_SEL = 4'd7; LD = 6'b000001; cyc();
    chk("ar_from_wrd", longint'(AR_OUT), 'h234);
    idle(); MEM_RD = 1; cyc();
    chk("rd_busy", longint'(BUSY), 1);
    MEM_RD = 0; cyc();
    #2; RST_N = 0; #1;
    chk("async_busy", longint'(BUSY), 0);
    chk("async_req", longint'(mem_req), 0);
    chk("async_ar", longint'(AR_OUT), 0);
    chk("async_addr", longint'(mem_addr), 0);
    cyc(); RST_N = 1;

    // Wrap and priority
    WRD = 16'h0FFF; BUS_SEL = 4'd7; LD = 6'b000001; cyc();
    LD = '0; INR = 6'b000001; cyc();
    chk("ar_wrap", longint'(AR_OUT), 0);
    INR = '0; WRD = 16'h0ABC; LD = 6'b000010; cyc();
    chk("pc_load", longint'(PC_OUT), 'hABC);
    CLR = 6'b000010; LD = 6'b000010; INR = 6'b000010; cyc();
    chk("pc_clr_prio", longint'(PC_OUT), 0);
    idle();

    // Read with three wait cycles, DR load ignored while busy
    WRD = 16'h0010; BUS_SEL = 4'd7; LD = 6'b000001; cyc();
    idle(); MEM_RD = 1; cyc();
    chk("rd_w1_busy", longint'(BUSY), 1);
    chk("rd_addr", longint'(mem_addr), 'h010);
    MEM_RD = 0; LD = 6'b000100; WRD = 16'h5555; cyc();
    chk("rd_w2_busy", longint'(BUSY), 1);
    cyc();
    chk("rd_w3_busy", longint'(BUSY), 1);
    mem_ready = 1; mem_rdata = 16'hBEEF; cyc();
    chk("rd_done_busy", longint'(BUSY), 0);
    chk("dr_stalled", longint'(DR_OUT), 0);
    mem_ready = 0; BUS_SEL = 4'd6; LD = 6'b000100; cyc();
    chk("dr_from_mdr", longint'(DR_OUT), 'hBEEF);

    // Write; a read request during WR_WAIT starts nothing
    load_dr_ac(16'h00FF);
    chk("ac_xfer", longint'(AC_OUT), 'h00FF);
    BUS_SEL = 4'd3; MEM_WR = 1; cyc();
    chk("wr_req", longint'(mem_req), 1);
    chk("wr_wdata", longint'(mem_wdata), 'h00FF);
    MEM_WR = 0; MEM_RD = 1; BUS_SEL = 4'd7; cyc();
    chk("wr_we_hold", longint'(mem_we), 1);
    chk("wr_addr_hold", longint'(mem_addr), 'h010);
    MEM_RD = 0; mem_ready = 1; cyc();
    chk("wr_done_req", longint'(mem_req), 0);
    mem_ready = 0; cyc();
    chk("no_stale_rd", longint'(BUSY), 0);

    // ALU and E
    load_dr_ac(16'h7FFF);
    WRD = 16'h0001; BUS_SEL = 4'd7; LD = 6'b000100; cyc();
    OPSEL_ALU = 3'd0; LD = 6'b001000; LD_E = 1; #1;
    chk("add_ovf", longint'(OVF), 1);
    chk("add_n", longint'(N), 1);
    cyc();
    chk("add_ac", longint'(AC_OUT), 'h8000);
    chk("add_e", longint'(E_OUT), 0);
    load_dr_ac(16'h0005);
    OPSEL_ALU = 3'd6; #1;
    chk("sub_z", longint'(Z), 1);
    chk("sub_co", longint'(CO), 1);
    load_dr_ac(16'h8000);
    OPSEL_ALU = 3'd0; LD_E = 1; cyc();
    chk("e_set", longint'(E_OUT), 1);
    OPSEL_ALU = 3'd5; LD = 6'b001000; LD_E = 1; cyc();
    chk("cil_ac", longint'(AC_OUT), 'h0001);
    chk("cil_e", longint'(E_OUT), 1);
    idle();

    // Randomized phase (read and write never together here)
    for (int k = 0; k < 400; k++) begin
      BUS_SEL   = 4'($urandom_range(0, 15));
      WRD       = DW'($urandom);
      LD        = 6'($urandom & $urandom);
      INR       = 6'($urandom & $urandom);
      CLR       = 6'($urandom & $urandom & $urandom);
      GPR_LD    = NG'($urandom & $urandom);
      OPSEL_ALU = 3'($urandom);
      LD_E      = ($urandom_range(0, 3) == 0);
      CMP_E     = ($urandom_range(0, 3) == 0);
      CLR_E     = ($urandom_range(0, 5) == 0);
      MEM_RD    = ($urandom_range(0, 6) == 0);
      MEM_WR    = !MEM_RD && ($urandom_range(0, 6) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = DW'($urandom);
      cyc();
    end
    idle(); mem_ready = 1; cyc(); cyc(); mem_ready = 0;
    chk("pre_err_clear", longint'(ERR), 0);

    // Simultaneous read and write sets sticky ERR; GPR round trip
    MEM_RD = 1; MEM_WR = 1; cyc();
    chk("err_no_req", longint'(mem_req), 0);
    chk("err_set", longint'(ERR), 1);
    idle(); cyc(); cyc(); cyc();
    chk("err_sticky", longint'(ERR), 1);
    WRD = 16'hA5C3; BUS_SEL = 4'd7; GPR_LD = 4'b0100; cyc();
    GPR_LD = '0; BUS_SEL = 4'd10; LD = 6'b000100; cyc();
    chk("gpr2_roundtrip", longint'(DR_OUT), 'hA5C3);
    idle();
    RST_N = 0; #1;
    chk("err_reset", longint'(ERR), 0);
    cyc(); RST_N = 1; cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bc_datapath_v2.md
Name: bc_datapath_v2

Overview:
Parametrised second-generation datapath for the basic computer. It provides:
- AR, PC, DR, AC, IR, TR and a NUM_GPR-entry general register file on one shared bus.
- An ALU with an E (extend) flip-flop.
- A variable-latency external memory port with req/ready handshake.

It replaces the fixed 16-bit datapath with its single-cycle internal memory. A built-in memory FSM stalls all register updates via BUSY. The control unit drives micro-ops one cycle at a time.

Parameters:
- DATA_W, 16, width of DR/AC/IR/TR/GPRs/bus; must be >= ADDR_W.
- ADDR_W, 12, width of AR/PC and memory address.
- NUM_GPR, 4, general registers R0..R(NUM_GPR-1); 1..8.

Ports:
- clk  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- BUS_SEL  in  4  bus source: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 MDR, 7 WRD, 8+i GPR i; other codes drive 0
- LD  in  6  load enables {TR,IR,AC,DR,PC,AR}, bit0=AR
- INR  in  6  increment enables, same order (IR bit ignored)
- CLR  in  6  clear enables, same order (IR bit ignored)
- GPR_LD  in  NUM_GPR  load GPR i from bus
- OPSEL_ALU  in  3  ALU operation
- LD_E, CMP_E, CLR_E  in  1 each  E flip-flop controls
- MEM_RD, MEM_WR  in  1 each  start memory read/write at address AR
- WRD  in  DATA_W  external word (bus source 7)
- mem_req  out  1  memory request
- mem_we  out  1  1=write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready on a read
- BUSY  out  1  memory transaction in flight
- ERR  out  1  sticky: MEM_RD and MEM_WR asserted together
- PC_OUT, AR_OUT  out  ADDR_W  register values
- IR_OUT, AC_OUT, DR_OUT  out  DATA_W  register values
- CO, Z, N, OVF, E_OUT  out  1 each  ALU flags, E value

Behaviour:
- Reset (async, RST_N=0):
  - All registers, GPRs, MDR, E and ERR go to 0.
  - FSM goes to IDLE; mem_req=0, mem_we=0, BUSY=0.
  - mem_addr and mem_wdata go to 0.
- Bus:
  - Combinational from BUS_SEL.
  - AR/PC are zero-extended to DATA_W.
  - AR/PC load from BUS[ADDR_W-1:0].
  - AC loads the ALU result, not the bus.
- Register priority per register: CLR > LD > INR.
  - INR wraps modulo 2^width (AR/PC 0xFFF -> 0x000).
- Stall: while BUSY=1, every LD/INR/CLR/GPR_LD and E control is ignored; registers hold.
- Memory FSM, states IDLE, RD_WAIT, WR_WAIT:
  - IDLE & MEM_RD & !MEM_WR: latch mem_addr=AR and mem_we=0; set mem_req=1; go to RD_WAIT.
  - IDLE & MEM_WR & !MEM_RD: latch mem_addr=AR, mem_wdata=BUS, mem_we=1; set mem_req=1; go to WR_WAIT.
  - IDLE & both asserted: no request; set ERR=1 (cleared only by reset).
  - Register micro-ops in the same cycle as the start still execute, because BUSY is still 0 in that cycle.
  - RD_WAIT & mem_ready: MDR <= mem_rdata; mem_req=0; go to IDLE.
  - WR_WAIT & mem_ready: mem_req=0; go to IDLE.
  - mem_req, mem_addr, mem_we and mem_wdata hold stable until mem_ready.
  - BUSY = (state != IDLE), registered.
  - MEM_RD/MEM_WR while BUSY are ignored.
  - mem_ready in IDLE is ignored.
  - Minimum read latency: 2 cycles from MEM_RD to MDR valid (mem_ready on the first wait cycle).
- ALU (combinational on AC, DR, E):
  - 000 ADD: AC+DR; CO=carry out.
  - 001 AND: AC&DR.
  - 010 XFER: DR.
  - 011 CMA: ~AC.
  - 100 CIR: {E, AC[DATA_W-1:1]}; CO=AC[0].
  - 101 CIL: {AC[DATA_W-2:0], E}; CO=AC[DATA_W-1].
  - 110 SUB: AC+~DR+1; CO=carry out, 1 means no borrow.
  - 111 PASS: AC.
  - CO=0 for ops that do not define it.
  - OVF is signed overflow for ADD/SUB, else 0.
  - Z = (result==0); N = result MSB.
  - E_next candidate = CO.
- E flip-flop priority: CLR_E > LD_E (E <= CO) > CMP_E (E <= ~E).

Decomposition:
- Package bc_v2_pkg holds:
  - BUS_SEL codes
  - register index constants (AR=0 ... TR=5)
  - ALU opcode constants
  - memory FSM state encoding
- One sub-module: bc_alu_v2 (parametrised DATA_W; ALU plus flag generation).
- Registers and the FSM stay inline.

Test Plan:
1. Reset mid-read: MEM_RD, then RST_N=0 while in RD_WAIT -> BUSY=0, mem_req=0, all outputs 0 immediately (asynchronous).
2. Bus/load: WRD=0x1234, BUS_SEL=7, LD[AR] -> AR_OUT=0x234. Then INR[AR] at AR=0xFFF -> 0x000. CLR+LD+INR on PC together -> PC=0.
3. Read with 3-cycle wait: AR=0x010, MEM_RD; mem_ready on the 3rd wait cycle with rdata=0xBEEF -> BUSY high 3 cycles, LD[DR] ignored while busy; after BUSY falls, BUS_SEL=6, LD[DR] -> DR=0xBEEF.
4. Write: AC=0x00FF, BUS_SEL=3, MEM_WR -> mem_addr=AR, mem_wdata=0x00FF, mem_we=1 held until mem_ready. MEM_RD during WR_WAIT produces no new request.
5. ALU/E:
   - AC=0x7FFF, DR=0x0001, ADD, LD[AC], LD_E -> AC=0x8000, OVF=1, N=1, E=0.
   - SUB with AC=DR=0x0005 -> Z=1, CO=1.
   - CIL on AC=0x8000 with E=1 -> AC=0x0001, LD_E gives E=1.
6. MEM_RD and MEM_WR in the same cycle -> no mem_req; ERR=1 and stays set until reset. GPR_LD[2] with BUS_SEL=10 round-trips the value.
